// File: rtl/ramdma_transfer_engine.sv
// ramdma_transfer_engine: bus-master DMA between the system bus and SSRAM port B, burst by burst; config writes accepted only when idle.
// Write data holds while busBusy (one-cycle SSRAM prefetch per burst); RAMDMA_DONE_IRQ_EN adds doneIrq gated by control bit2.
module ramdma_transfer_engine #(
  parameter int memoryAddressWidth = 9,
  parameter int blockSizeWidth     = 10
) (
  input  logic                          clock,
  input  logic                          reset,
`ifdef RAMDMA_DONE_IRQ_EN
  output logic                          doneIrq,
`endif
  input  logic                          cfgWrite,
  input  logic [2:0]                    cfgSelect,
  input  logic [31:0]                   cfgData,
  output logic [31:0]                   cfgReadData,
  output logic [memoryAddressWidth-1:0] memAddressB,
  output logic                          memWriteEnableB,
  output logic [31:0]                   memDataInB,
  input  logic [31:0]                   memDataOutB,
  output logic                          busRequest,
  input  logic                          busGrant,
  output logic                          beginTransaction,
  output logic [31:0]                   busAddress,
  output logic [7:0]                    burstSize,
  output logic                          readNotWrite,
  input  logic [31:0]                   busDataIn,
  input  logic                          busDataValidIn,
  output logic [31:0]                   busDataOut,
  output logic                          busDataValidOut,
  input  logic                          busBusy,
  input  logic                          endTransactionIn,
  output logic                          endTransactionOut,
  input  logic                          busError
);
  localparam int AW = memoryAddressWidth;
  localparam int BW = blockSizeWidth;

  typedef enum logic [2:0] {IDLE, REQ, BURST, READ, PREFETCH, WRITE, ENDWRITE, NEXT} state_t;
  state_t state, nextState;

  logic [31:0]   busStartReg, curBusAddr;
  logic [AW-1:0] memStartReg, curMemAddr;
  logic [BW-1:0] blockSizeReg, remaining, burstLimit, burstLen;
  logic [7:0]    burstReg;
  logic [2:0]    controlReg;
  logic [8:0]    burstCount;
  logic          errorReg, dirRead;
  logic          cfgIdleWrite, startCmd, startGo, wordRead, wordWrite, abort;

  assign cfgIdleWrite = cfgWrite && (state == IDLE);
  assign startCmd     = cfgIdleWrite && (cfgSelect == 3'd4) && (cfgData[0] ^ cfgData[1]);
  assign startGo      = startCmd && (blockSizeReg != '0);
  assign wordRead     = (state == READ) && busDataValidIn && (burstCount != 9'd0);
  assign wordWrite    = (state == WRITE) && !busBusy;
  assign abort        = (state != IDLE) && busError;
  assign burstLimit   = BW'({1'b0, burstReg}) + BW'(1);
  assign burstLen     = (remaining < burstLimit) ? remaining : burstLimit;

  always_comb begin
    cfgReadData = '0;
    case (cfgSelect)
      3'd0:    cfgReadData = busStartReg;
      3'd1:    cfgReadData = 32'(memStartReg);
      3'd2:    cfgReadData = 32'(blockSizeReg);
      3'd3:    cfgReadData = 32'(burstReg);
      3'd4:    cfgReadData = 32'(controlReg);
      3'd5:    cfgReadData = {30'd0, errorReg, state != IDLE};
      default: cfgReadData = '0;
    endcase
  end

  always_comb begin
    nextState         = state;
    memAddressB       = '0;
    memWriteEnableB   = 1'b0;
    memDataInB        = '0;
    busRequest        = 1'b0;
    beginTransaction  = 1'b0;
    busAddress        = '0;
    burstSize         = '0;
    readNotWrite      = 1'b0;
    busDataOut        = '0;
    busDataValidOut   = 1'b0;
    endTransactionOut = 1'b0;
    case (state)
      IDLE: if (startGo) nextState = REQ;
      REQ: begin
        busRequest = 1'b1;
        if (busGrant) nextState = BURST;
      end
      BURST: begin
        busRequest       = 1'b1;
        beginTransaction = 1'b1;
        busAddress       = curBusAddr;
        burstSize        = 8'(burstLen - BW'(1));
        readNotWrite     = dirRead;
        nextState        = dirRead ? READ : PREFETCH;
      end
      READ: begin
        busRequest  = 1'b1;
        memAddressB = curMemAddr;
        if (wordRead) begin
          memWriteEnableB = 1'b1;
          memDataInB      = busDataIn;
        end
        if (endTransactionIn) nextState = NEXT;
      end
      PREFETCH: begin
        busRequest  = 1'b1;
        memAddressB = curMemAddr;
        nextState   = WRITE;
      end
      WRITE: begin
        busRequest      = 1'b1;
        busDataValidOut = 1'b1;
        busDataOut      = memDataOutB;
        // Holding the address during a stall keeps the SSRAM output, and so the bus data, frozen.
        memAddressB     = busBusy ? curMemAddr : curMemAddr + AW'(1);
        if (wordWrite && burstCount == 9'd1) nextState = ENDWRITE;
      end
      ENDWRITE: begin
        busRequest        = 1'b1;
        endTransactionOut = 1'b1;
        nextState         = NEXT;
      end
      NEXT: nextState = (remaining != '0) ? REQ : IDLE;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      busStartReg  <= '0;
      memStartReg  <= '0;
      blockSizeReg <= '0;
      burstReg     <= '0;
      controlReg   <= '0;
      errorReg     <= 1'b0;
      dirRead      <= 1'b0;
      curBusAddr   <= '0;
      curMemAddr   <= '0;
      remaining    <= '0;
      burstCount   <= '0;
`ifdef RAMDMA_DONE_IRQ_EN
      doneIrq      <= 1'b0;
`endif
    end else begin
      state <= nextState;
      if (cfgIdleWrite) begin
        case (cfgSelect)
          3'd0:    busStartReg  <= {cfgData[31:2], 2'b00};
          3'd1:    memStartReg  <= cfgData[AW-1:0];
          3'd2:    blockSizeReg <= cfgData[BW-1:0];
          3'd3:    burstReg     <= cfgData[7:0];
          3'd4:    controlReg   <= cfgData[2:0];
          default: ;
        endcase
      end
      if (startCmd) errorReg <= 1'b0;
      if (startGo) begin
        curBusAddr <= busStartReg;
        curMemAddr <= memStartReg;
        remaining  <= blockSizeReg;
        dirRead    <= cfgData[0];
      end
      if (state == BURST) burstCount <= 9'(burstLen);
      // Counters move per word actually transferred, so a short read burst leaves the rest pending.
      if (wordRead || wordWrite) begin
        curBusAddr <= curBusAddr + 32'd4;
        curMemAddr <= curMemAddr + AW'(1);
        remaining  <= remaining - BW'(1);
        burstCount <= burstCount - 9'd1;
      end
      if (abort) errorReg <= 1'b1;
`ifdef RAMDMA_DONE_IRQ_EN
      doneIrq <= controlReg[2] && (state != IDLE) && (nextState == IDLE);
`endif
    end
  end
endmodule

// File: tb/tb_ramdma_transfer_engine.sv
// Bench for ramdma_transfer_engine: randomized bus slave plus SSRAM model, checked against a word-level transfer model.
`timescale 1ns/1ps
module tb_ramdma_transfer_engine;
  logic        clock = 1'b0;
  logic        reset;
  logic        cfgWrite;
  logic [2:0]  cfgSelect;
  logic [31:0] cfgData, cfgReadData;
  logic [8:0]  memAddressB;
  logic        memWriteEnableB;
  logic [31:0] memDataInB, memDataOutB;
  logic        busRequest, busGrant, beginTransaction, readNotWrite;
  logic [31:0] busAddress, busDataIn, busDataOut;
  logic [7:0]  burstSize;
  logic        busDataValidIn, busDataValidOut, busBusy;
  logic        endTransactionIn, endTransactionOut, busError;
`ifdef RAMDMA_DONE_IRQ_EN
  logic        doneIrq;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem    [512];
  logic [31:0] refMem [512];
  logic [31:0] memQ;
  logic        plWe = 1'b0;
  logic [8:0]  plAddr = '0;
  logic [31:0] plData = '0;

  always #5 clock = ~clock;

  ramdma_transfer_engine dut (
    .clock(clock), .reset(reset),
`ifdef RAMDMA_DONE_IRQ_EN
    .doneIrq(doneIrq),
`endif
    .cfgWrite(cfgWrite), .cfgSelect(cfgSelect), .cfgData(cfgData), .cfgReadData(cfgReadData),
    .memAddressB(memAddressB), .memWriteEnableB(memWriteEnableB), .memDataInB(memDataInB),
    .memDataOutB(memDataOutB), .busRequest(busRequest), .busGrant(busGrant),
    .beginTransaction(beginTransaction), .busAddress(busAddress), .burstSize(burstSize),
    .readNotWrite(readNotWrite), .busDataIn(busDataIn), .busDataValidIn(busDataValidIn),
    .busDataOut(busDataOut), .busDataValidOut(busDataValidOut), .busBusy(busBusy),
    .endTransactionIn(endTransactionIn), .endTransactionOut(endTransactionOut), .busError(busError)
  );

  // Synchronous SSRAM port B, one-cycle read latency; the bench preloads through the same port.
  always @(posedge clock) begin
    if (plWe) mem[plAddr] <= plData;
    else if (memWriteEnableB) mem[memAddressB] <= memDataInB;
    memQ <= mem[memAddressB];
  end
  assign memDataOutB = memQ;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic cfgWr(input logic [2:0] sel, input logic [31:0] data);
    @(negedge clock);
    cfgWrite = 1'b1; cfgSelect = sel; cfgData = data;
    @(negedge clock);
    cfgWrite = 1'b0; cfgSelect = 3'd5;
  endtask

  task automatic checkNoStart(input string tag, input int size, input logic [31:0] ctrl);
    logic reqSeen;
    cfgWr(3'd2, size);
    cfgWr(3'd4, ctrl);
    reqSeen = busRequest;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      busGrant = busRequest;
      reqSeen = reqSeen | busRequest | beginTransaction;
    end
    busGrant = 1'b0;
    checkValue(tag, 32'(reqSeen), 0);
    checkValue({tag, "Status"}, cfgReadData, 0);
  endtask

  task automatic runTransfer(input bit rnw, input int memStart, input int size, input int burst,
                             input logic [31:0] busStart, input int earlyEnd, input int stallWord,
                             input int errWord, input bit randomBusy, input logic [31:0] fixedData);
    int mRem, mMem, bursts, ends, sent, toSend, burstLeft, wordsDone, stallLeft, expLen, mismatches;
    logic [31:0] mBus, d;
    bit readOn, errPending, finished;
    cfgWr(3'd0, busStart);
    cfgWr(3'd1, memStart);
    cfgWr(3'd2, size);
    cfgWr(3'd3, burst);
    mRem = size; mMem = memStart; mBus = busStart;
    bursts = 0; ends = 0; sent = 0; toSend = 0; burstLeft = 0; wordsDone = 0; stallLeft = 3;
    readOn = 0; errPending = 0; finished = 0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clock);
      if (errPending) begin
        busError = 1'b0;
        checkValue("errDrop", 32'({busRequest, beginTransaction, busDataValidOut,
                                   endTransactionOut, memWriteEnableB}), 0);
        checkValue("errStatus", cfgReadData, 32'h2);
        finished = 1;
      end else begin
        if (cyc == 2) checkValue("startStatus", cfgReadData, 32'h1);
        if (cyc >= 2 && cfgSelect == 3'd5 && cfgReadData[0] == 1'b0) finished = 1;
      end
      if (!finished) begin
        busDataValidIn = 1'b0; endTransactionIn = 1'b0; busError = 1'b0; busBusy = 1'b0;
        cfgWrite = 1'b0;
        if (readOn) begin
          if (errWord >= 0 && sent == errWord) begin
            busError = 1'b1; errPending = 1; readOn = 0;
          end else if ($urandom_range(0, 3) != 0) begin
            d = (fixedData != 0) ? fixedData + 32'(sent) : $urandom;
            busDataValidIn = 1'b1; busDataIn = d;
            refMem[mMem] = d; mMem = (mMem + 1) % 512; mBus += 4; mRem--; sent++;
            if (sent == toSend) begin endTransactionIn = 1'b1; readOn = 0; end
          end
        end
        if (beginTransaction) begin
          expLen = (mRem < burst + 1) ? mRem : burst + 1;
          checkValue("burstAddr", busAddress, mBus);
          checkValue("burstLen", 32'(burstSize) + 1, expLen);
          checkValue("burstDir", 32'(readNotWrite), 32'(rnw));
          bursts++; burstLeft = expLen;
          if (rnw) begin
            readOn = 1; sent = 0;
            toSend = (earlyEnd > 0 && bursts == 1) ? earlyEnd : expLen;
          end
        end
        if (busDataValidOut) begin
          checkValue("writeData", busDataOut, refMem[mMem]);
          if (stallWord >= 0 && wordsDone == stallWord && stallLeft > 0) begin
            busBusy = 1'b1; stallLeft--;
          end else if (randomBusy && $urandom_range(0, 2) == 0) begin
            busBusy = 1'b1;
          end
          if (busBusy) begin
            #1 checkValue("stallAddr", 32'(memAddressB), mMem);
          end else begin
            mMem = (mMem + 1) % 512; mBus += 4; mRem--; burstLeft--; wordsDone++;
          end
        end
        if (endTransactionOut) begin
          ends++;
          checkValue("endAfterBurst", burstLeft, 0);
        end
        if (cyc == 0) begin
          cfgWrite = 1'b1; cfgSelect = 3'd4; cfgData = rnw ? 32'h1 : 32'h2;
        end else if (cyc == 3) begin
          cfgWrite = 1'b1; cfgSelect = 3'd3; cfgData = 32'h77;
        end else begin
          cfgSelect = 3'd5;
        end
        busGrant = busRequest && ($urandom_range(0, 1) == 1);
      end
    end
    busGrant = 1'b0; busBusy = 1'b0; busError = 1'b0;
    busDataValidIn = 1'b0; endTransactionIn = 1'b0; cfgWrite = 1'b0; cfgSelect = 3'd5;
    if (!finished) checkValue("timeout", 1, 0);
    if (errWord < 0) begin
      checkValue("remaining", mRem, 0);
      if (earlyEnd == 0) checkValue("burstCount", bursts, (size + burst) / (burst + 1));
      if (!rnw) checkValue("endCount", ends, bursts);
      #1 checkValue("finalStatus", cfgReadData, 0);
      mismatches = 0;
      for (int i = 0; i < 512; i++) if (mem[i] !== refMem[i]) mismatches++;
      checkValue("memory", mismatches, 0);
      cfgSelect = 3'd3;
      #1 checkValue("cfgLockedWhileBusy", cfgReadData, burst);
      cfgSelect = 3'd5;
    end
  endtask

  initial begin
    logic [31:0] d;
    bit seen;
    reset = 1'b1; cfgWrite = 1'b0; cfgSelect = 3'd0; cfgData = '0; busGrant = 1'b0;
    busDataIn = '0; busDataValidIn = 1'b0; busBusy = 1'b0; endTransactionIn = 1'b0; busError = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int sel = 0; sel < 6; sel++) begin
      cfgSelect = 3'(sel);
      #1 checkValue($sformatf("resetReg%0d", sel), cfgReadData, 0);
    end
    checkValue("resetOutputs", 32'({busRequest, beginTransaction, memWriteEnableB, busDataValidOut,
                                    endTransactionOut, readNotWrite}), 0);
    checkValue("resetMemAddr", 32'(memAddressB), 0);

    for (int i = 0; i < 512; i++) begin
      d = $urandom;
      refMem[i] = d;
      @(negedge clock);
      plWe = 1'b1; plAddr = 9'(i); plData = d;
    end
    @(negedge clock);
    plWe = 1'b0;

    cfgWr(3'd0, 32'h0000_1003);
    cfgSelect = 3'd0;
    #1 checkValue("busAddrAlign", cfgReadData, 32'h0000_1000);

    checkNoStart("sizeZeroNoReq", 0, 32'h1);
    checkNoStart("bothDirNoReq", 4, 32'h3);

    runTransfer(1, 0, 4, 3, 32'h1000, 0, -1, -1, 0, 32'hA0);
    checkValue("ssram0", mem[0], 32'hA0);
    checkValue("ssram3", mem[3], 32'hA3);
    runTransfer(0, 10, 6, 1, 32'h2000, 0, -1, -1, 0, 0);
    runTransfer(1, 510, 4, 7, 32'h3000, 0, -1, -1, 1, 0);
    checkValue("wrapTo0", mem[0], refMem[0]);
    runTransfer(0, 100, 5, 7, 32'h4000, 0, 2, -1, 0, 0);
    runTransfer(1, 200, 6, 3, 32'h5000, 2, -1, -1, 1, 0);
    runTransfer(1, 300, 8, 7, 32'h6000, 0, -1, 1, 0, 0);
    runTransfer(1, 320, 3, 1, 32'h6100, 0, -1, -1, 0, 0);
    for (int t = 0; t < 6; t++)
      runTransfer(bit'($urandom_range(0, 1)), $urandom_range(0, 511), $urandom_range(1, 20),
                  $urandom_range(0, 7), $urandom & 32'hFFFF_FFFC, 0, -1, -1, 1, 0);

    cfgWr(3'd0, 32'h7000);
    cfgWr(3'd1, 32'd40);
    cfgWr(3'd2, 32'd8);
    cfgWr(3'd3, 32'd3);
    cfgWr(3'd4, 32'h1);
    seen = 0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
      @(negedge clock);
      if (beginTransaction) seen = 1;
      else busGrant = busRequest;
    end
    checkValue("resetBeginSeen", 32'(seen), 1);
    #2 reset = 1'b1;
    #1 checkValue("resetMidReq", 32'({busRequest, beginTransaction, busDataValidOut, memWriteEnableB}), 0);
    checkValue("resetMidStatus", cfgReadData, 0);
    busGrant = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ramdma_transfer_engine.md
Name: ramdma_transfer_engine

Overview:
- DMA engine driving port B of the 512x32 dual-port SSRAM that the CPU reaches through the ramDma custom instruction on port A.
- Moves blocks of words between the system bus and the SSRAM, in bursts, as a bus master.
- Configured and polled through a small register interface that the custom-instruction decoder forwards.

Parameters:
- memoryAddressWidth, 9, SSRAM port-B address width (512 entries).
- blockSizeWidth, 10, width of the block-size register (max 1023 words).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfgWrite  in  1  register write strobe.
- cfgSelect  in  3  register index.
- cfgData  in  32  register write data.
- cfgReadData  out  32  combinational readback of the register at cfgSelect.
- memAddressB  out  9  SSRAM port-B address.
- memWriteEnableB  out  1  SSRAM port-B write enable.
- memDataInB  out  32  SSRAM port-B write data.
- memDataOutB  in  32  SSRAM port-B read data; valid 1 cycle after the address.
- busRequest  out  1  bus request.
- busGrant  in  1  bus grant.
- beginTransaction  out  1  one-cycle burst start.
- busAddress  out  32  burst start byte address; valid while beginTransaction is high.
- burstSize  out  8  words minus 1; valid while beginTransaction is high.
- readNotWrite  out  1  1 = bus read; valid while beginTransaction is high.
- busDataIn  in  32  bus read data.
- busDataValidIn  in  1  read data valid.
- busDataOut  out  32  bus write data.
- busDataValidOut  out  1  write data valid.
- busBusy  in  1  slave stall on write data.
- endTransactionIn  in  1  slave ends a read burst.
- endTransactionOut  out  1  master ends a write burst (one cycle).
- busError  in  1  bus error.

Behaviour:
- Registers (write only when idle; writes while busy are ignored):
  - 0: bus start address; bits 1:0 forced to 0.
  - 1: memory start address, 9 bits.
  - 2: block size in words, 10 bits.
  - 3: burst size minus 1, 8 bits.
  - 4: control. Bit0 = start bus->mem; bit1 = start mem->bus; both set = no action.
  - 5: status, read-only. Bit0 busy, bit1 error.
- Reset values: all registers 0. All outputs 0 except cfgReadData, which reflects registers.
- States and transitions:
  - IDLE: wait for a start command.
  - REQ: assert busRequest until busGrant.
  - BEGIN: one cycle; beginTransaction=1; burst length = min(remaining, burstSize+1).
  - READ: each busDataValidIn writes busDataIn to memAddressB on the same cycle; address increments.
  - PREFETCH: one cycle; present the first memory address.
  - WRITE: drive busDataValidOut with SSRAM data. While busBusy, hold data, valid and address stable; advance only on a cycle with busBusy=0. After the last word, one cycle of endTransactionOut.
  - NEXT: if remaining > 0, go to REQ; otherwise go to IDLE and clear busy.
- Address arithmetic:
  - Bus address +4 per word.
  - Memory address wraps modulo 512 (511 -> 0).
  - Remaining count decrements per word transferred.
- Block size 0: start sets no busy and issues no bus activity.
- busRequest stays high from REQ through the end of each burst and drops for one cycle between bursts.
- Read burst termination:
  - endTransactionIn ends the read burst, even if fewer words arrived.
  - In that case the remaining count still counts only the words actually received.
- busError in any non-IDLE state: abort, drop all bus outputs next cycle, set the error bit, go to IDLE. The error bit clears on the next valid start.
- Reset asserted mid-transfer: all outputs drop asynchronously; the state returns to IDLE.
- Status reads are legal at any time.

Optional Feature:
- Macro: RAMDMA_DONE_IRQ_EN.
- When defined:
  - Adds output doneIrq (1 bit), pulsed for one cycle when a transfer completes or aborts.
  - Adds control bit2 as interrupt enable; doneIrq pulses only when bit2 is set.
- When undefined: no port, bit2 ignored, behaviour otherwise identical.

Test Plan:
- bus->mem: addr 0x1000, mem 0, size 4, burst 3; slave returns 0xA0..0xA3 -> SSRAM[0..3]=0xA0..0xA3, one burst, busy clears.
- mem->bus: SSRAM[10..15] preloaded, size 6, burst 1 -> three bursts at 0x2000, 0x2008, 0x2010. Each burst has 2 valid words; endTransactionOut appears 3 times.
- Wrap: mem start 510, size 4, bus->mem -> writes land at 510, 511, 0, 1.
- Stall: busBusy held for 3 cycles mid-write burst -> busDataOut stable, no word lost or duplicated.
- Error: busError on the 2nd read word of size 8 -> bus outputs drop next cycle, status=0b10, restart clears the error.
- Reset and start edge cases:
  - Reset asserted mid-burst -> busRequest=0 immediately, status=0.
  - Start with size 0 -> no busRequest.
